csa_resolve_acc: RTL

Consumer of the carry-save product pair emitted by the partial-product multiplier (two P+1-bit vectors whose sum modulo 2^P is the signed product, P=N+M).
- Resolves each pair with a sequential chunked carry-propagate adder.
- Sign-extends the result and accumulates it into an ACC_W-bit signed accumulator.
- Delivers the total on a valid/ready output when the input beat is flagged last.
- Sits between the multiplier array and the DSP output register/post-adder.

---
 rtl/csa_resolve_acc_pkg.sv | 26 ++
 rtl/csa_resolve_acc_cpa_chunk.sv | 20 ++
 rtl/csa_resolve_acc.sv | 138 +++++++++++++
 3 files changed

// File: rtl/csa_resolve_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_resolve_acc_pkg
// Description : Shared state encoding, default sizes and helper for the
//               carry-save resolve/accumulate block.
// Revision    : 1.0
// ============================================================================
package csa_resolve_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Sizes for the default 17x17 multiplier with 9-bit chunks
    localparam int c_p_def   = 17 + 17;
    localparam int c_nch_def = ceil_div(c_p_def, 9);

endpackage : csa_resolve_acc_pkg
`default_nettype wire

// File: rtl/csa_resolve_acc_cpa_chunk.sv
`default_nettype none
// ============================================================================
// Module      : cpa_chunk
// Description : W-bit combinational adder with carry in and carry out.
// Revision    : 1.0
// ============================================================================
module cpa_chunk #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule : cpa_chunk
`default_nettype wire

// File: rtl/csa_resolve_acc.sv
`default_nettype none
// ============================================================================
// Module      : csa_resolve_acc
// Description : Resolves a carry-save product pair chunk by chunk, then
//               sign-extends and accumulates it; emits the total on last.
// Revision    : 1.0
// ============================================================================
module csa_resolve_acc
    import csa_resolve_acc_pkg::*;
#(
    parameter int N     = 17,
    parameter int M     = 17,
    parameter int ACC_W = 48,
    parameter int CHUNK = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+M:0]     in_a,
    input  logic [N+M:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int c_p   = N + M;
    localparam int c_nch = ceil_div(c_p, CHUNK);
    localparam int c_w   = c_nch * CHUNK;
    localparam int c_kw  = (c_nch > 1) ? $clog2(c_nch) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_w-1:0]     r_a;
    logic [c_w-1:0]     r_b;
    logic [c_w-1:0]     r_result;
    logic               r_last;
    logic               r_carry;
    logic [c_kw-1:0]    r_k;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_k_last;
    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_ovf_now;
    logic               w_unused_msb;

    // Operands shift right each ADD cycle, so the adder always sees bits [CHUNK-1:0]
    cpa_chunk #(.W(CHUNK)) u_cpa (
        .i_a    (r_a[CHUNK-1:0]),
        .i_b    (r_b[CHUNK-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_k_last     = (r_k == c_kw'(c_nch - 1));
    assign w_ext        = ACC_W'($signed(r_result[c_p-1:0]));
    assign w_acc_sum    = r_acc + w_ext;
    assign w_ovf_now    = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                          (w_acc_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_unused_msb = in_a[c_p] ^ in_b[c_p];

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_OUT);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_ADD;
            ST_ADD:  if (w_k_last)  w_state_nxt = ST_ACC;
            ST_ACC:  w_state_nxt = r_last ? ST_OUT : ST_IDLE;
            ST_OUT:  if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_last   <= 1'b0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= c_w'(in_a[c_p-1:0]);
                        r_b     <= c_w'(in_b[c_p-1:0]);
                        r_last  <= in_last;
                        r_k     <= '0;
                        r_carry <= 1'b0;
                    end
                end
                ST_ADD: begin
                    // Each new chunk enters at the top; after NCH cycles the result is aligned
                    r_a      <= r_a >> CHUNK;
                    r_b      <= r_b >> CHUNK;
                    r_result <= (r_result >> CHUNK) | (c_w'(w_sum) << (c_w - CHUNK));
                    r_carry  <= w_cout;
                    r_k      <= r_k + c_kw'(1);
                end
                ST_ACC: begin
                    r_acc <= w_acc_sum;
                    r_ovf <= r_ovf | w_ovf_now;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : csa_resolve_acc
`default_nettype wire
